// File: rtl/adc_window_averager.sv
// Averages 2^LOG2_AVG four-channel ADC samples per window and emits the truncated means.
// Define ADC_MINMAX_EN to add per-window min_out_o/max_out_o outputs.
module adc_window_averager #(
  parameter int LOG2_AVG = 4,
  parameter int CH_W     = 12
) (
  input  logic              ref_clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              sample_valid_i,
  input  logic [4*CH_W-1:0] ch_in_i,
  output logic [4*CH_W-1:0] avg_out_o,
  output logic              avg_valid_o,
  output logic [15:0]       window_count_o
`ifdef ADC_MINMAX_EN
  ,
  output logic [4*CH_W-1:0] min_out_o,
  output logic [4*CH_W-1:0] max_out_o
`endif
);

  localparam int N     = 1 << LOG2_AVG;
  localparam int ACC_W = CH_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q [4];
  logic [ACC_W-1:0]  acc_d [4];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4*CH_W-1:0] avg_q, avg_d;
  logic              valid_q, valid_d;
  logic [15:0]       win_q, win_d;
  logic [CH_W-1:0]   ch [4];

`ifdef ADC_MINMAX_EN
  logic [CH_W-1:0]   min_q [4];
  logic [CH_W-1:0]   min_d [4];
  logic [CH_W-1:0]   max_q [4];
  logic [CH_W-1:0]   max_d [4];
  logic [4*CH_W-1:0] min_out_q, min_out_d;
  logic [4*CH_W-1:0] max_out_q, max_out_d;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch[i] = ch_in_i[i*CH_W +: CH_W];
    end
  end

  // Enable low overrides every state; the DUMP strobe opens the next window so no sample is lost.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    win_d   = win_q;
`ifdef ADC_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
    min_out_d = min_out_q;
    max_out_d = max_out_q;
`endif
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      for (int i = 0; i < 4; i++) begin
        acc_d[i] = '0;
`ifdef ADC_MINMAX_EN
        min_d[i] = '1;
        max_d[i] = '0;
`endif
      end
    end else begin
      case (state_q)
        IDLE: state_d = ACCUM;
        ACCUM: begin
          if (sample_valid_i) begin
            cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < 4; i++) begin
              acc_d[i] = acc_q[i] + ACC_W'(ch[i]);
`ifdef ADC_MINMAX_EN
              if (cnt_q == '0) begin
                min_d[i] = ch[i];
                max_d[i] = ch[i];
              end else begin
                if (ch[i] < min_q[i]) min_d[i] = ch[i];
                if (ch[i] > max_q[i]) max_d[i] = ch[i];
              end
`endif
            end
            if (cnt_q == LAST) state_d = DUMP;
          end
        end
        DUMP: begin
          valid_d = 1'b1;
          win_d   = win_q + 16'd1;
          for (int i = 0; i < 4; i++) begin
            avg_d[i*CH_W +: CH_W] = acc_q[i][ACC_W-1:LOG2_AVG];
`ifdef ADC_MINMAX_EN
            min_out_d[i*CH_W +: CH_W] = min_q[i];
            max_out_d[i*CH_W +: CH_W] = max_q[i];
`endif
          end
          if (sample_valid_i) begin
            // With N=1 the accepted sample already completes a window.
            state_d = (N == 1) ? DUMP : ACCUM;
            cnt_d   = CNT_W'(1);
            for (int i = 0; i < 4; i++) begin
              acc_d[i] = ACC_W'(ch[i]);
`ifdef ADC_MINMAX_EN
              min_d[i] = ch[i];
              max_d[i] = ch[i];
`endif
            end
          end else begin
            state_d = ACCUM;
            cnt_d   = '0;
            for (int i = 0; i < 4; i++) begin
              acc_d[i] = '0;
`ifdef ADC_MINMAX_EN
              min_d[i] = '1;
              max_d[i] = '0;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
`ifdef ADC_MINMAX_EN
        min_q[i] <= '1;
        max_q[i] <= '0;
`endif
      end
`ifdef ADC_MINMAX_EN
      min_out_q <= '0;
      max_out_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
`ifdef ADC_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
      min_out_q <= min_out_d;
      max_out_q <= max_out_d;
`endif
    end
  end

  assign avg_out_o      = avg_q;
  assign avg_valid_o    = valid_q;
  assign window_count_o = win_q;
`ifdef ADC_MINMAX_EN
  assign min_out_o = min_out_q;
  assign max_out_o = max_out_q;
`endif

endmodule
